// File: rtl/serial_sub_pkg.sv
// Shared definitions for the serial subtractor: FSM state encoding and default geometry.
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_N = 32;
    localparam int DEF_W = 8;

endpackage

// File: rtl/sub_chunk.sv
// Combinational W-bit ripple subtractor: diff = a - b - bin, with borrow-out and the
// borrow entering the top bit (used by the top level for signed overflow).
module sub_chunk #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         bin,
    output logic [W-1:0] diff,
    output logic         bout,
    output logic         msb_bin
);

    logic brw;

    // NOTE: every variable written here gets a default first so no latch is inferred.
    always_comb begin
        brw     = bin;
        msb_bin = 1'b0;
        diff    = '0;
        for (int i = 0; i < W; i++) begin
            if (i == W - 1) msb_bin = brw;
            diff[i] = a[i] ^ b[i] ^ brw;
            brw     = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & brw);
        end
        bout = brw;
    end

endmodule

// File: rtl/serial_subtractor.sv
// Serial N-bit subtractor processing W bits per cycle through one shared sub_chunk.
// Define SERIAL_SUB_OVF_EN to add the signed-overflow output ovf.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int N = DEF_N,
    parameter int W = DEF_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    input  logic         bi,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] d,
    output logic         bo
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic         ovf
`endif
);

    localparam int CHUNKS = N / W;
    localparam int CW     = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
    localparam logic [CW-1:0] LAST = CW'(CHUNKS - 1);

    state_t        state, state_nxt;
    logic [CW-1:0] cnt;
    logic [N-1:0]  xr, yr, acc, res;
    logic          brw;
    logic          last;
    logic [W-1:0]  diff;
    logic          bout;
`ifdef SERIAL_SUB_OVF_EN
    logic          msb_bin;
`else
    logic          msb_bin_unused;
`endif

    assign last = (cnt == LAST);

    sub_chunk #(.W(W)) u_chunk (
        .a       (xr[int'(cnt)*W +: W]),
        .b       (yr[int'(cnt)*W +: W]),
        .bin     (brw),
        .diff    (diff),
        .bout    (bout),
`ifdef SERIAL_SUB_OVF_EN
        .msb_bin (msb_bin)
`else
        .msb_bin (msb_bin_unused)
`endif
    );

    // The last chunk is always the MSB chunk, so the final result is the
    // accumulated low chunks with the current chunk dropped on top.
    always_comb begin
        res          = acc;
        res[N-1 -: W] = diff;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)  state_nxt = RUN;
            RUN:     if (last)      state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE) && !rst;
        out_valid = (state == DONE);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            xr  <= '0;
            yr  <= '0;
            brw <= 1'b0;
            acc <= '0;
            cnt <= '0;
            d   <= '0;
            bo  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            ovf <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        xr  <= x;
                        yr  <= y;
                        brw <= bi;
                        cnt <= '0;
                    end
                end
                RUN: begin
                    acc[int'(cnt)*W +: W] <= diff;
                    brw                   <= bout;
                    if (last) begin
                        cnt <= '0;
                        d   <= res;
                        bo  <= bout;
`ifdef SERIAL_SUB_OVF_EN
                        ovf <= msb_bin ^ bout;
`endif
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (N=32, W=8): arithmetic scoreboard model,
// per-cycle compare at negedge, and directed vectors with literal expectations.
module tb_serial_subtractor;

    localparam int N  = 32;
    localparam int W  = 8;
    localparam int CH = N / W;

    logic         clk, rst;
    logic         in_valid, in_ready, out_valid, out_ready;
    logic [N-1:0] x, y, d;
    logic         bi, bo;
`ifdef SERIAL_SUB_OVF_EN
    logic         ovf;
`endif

    int total = 0;
    int bad   = 0;

    serial_subtractor #(.N(N), .W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .y         (y),
        .bi        (bi),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .d         (d),
        .bo        (bo)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Arithmetic model: plain wide-integer subtraction, unsigned for d/bo, signed for ovf.
    function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic c,
                                  output logic [31:0] rd, output logic rbo, output logic rovf);
        longint ua, ub, ud, sa, sb, sd;
        ua   = a;
        ub   = b;
        ud   = ua - ub - longint'(c);
        rd   = ud[31:0];
        rbo  = (ua < ub + longint'(c));
        sa   = longint'($signed(a));
        sb   = longint'($signed(b));
        sd   = sa - sb - longint'(c);
        rovf = (sd > 64'sd2147483647) || (sd < -64'sd2147483648);
    endfunction

    // Scoreboard: one operation in flight, result due CH edges after acceptance.
    bit          busy;
    longint      cyc, t_acc;
    logic [31:0] pend_d, prev_d;
    logic        pend_bo, prev_bo, pend_ovf, prev_ovf;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            busy     = 1'b0;
            cyc      = 0;
            t_acc    = 0;
            pend_d   = '0; pend_bo = 1'b0; pend_ovf = 1'b0;
            prev_d   = '0; prev_bo = 1'b0; prev_ovf = 1'b0;
        end else begin
            if (busy && (cyc - t_acc >= CH)) begin
                if (out_ready) begin
                    busy     = 1'b0;
                    prev_d   = pend_d;
                    prev_bo  = pend_bo;
                    prev_ovf = pend_ovf;
                end
            end else if (!busy && in_valid) begin
                busy  = 1'b1;
                t_acc = cyc + 1;
                model(x, y, bi, pend_d, pend_bo, pend_ovf);
            end
            cyc = cyc + 1;
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            check("rst_in_ready", in_ready, 0);
            check("rst_out_valid", out_valid, 0);
            check("rst_d", d, 0);
            check("rst_bo", bo, 0);
`ifdef SERIAL_SUB_OVF_EN
            check("rst_ovf", ovf, 0);
`endif
        end else begin
            logic ov;
            ov = busy && (cyc - t_acc >= CH);
            check("cyc_in_ready", in_ready, !busy);
            check("cyc_out_valid", out_valid, ov);
            if (ov) begin
                check("cyc_d", d, pend_d);
                check("cyc_bo", bo, pend_bo);
`ifdef SERIAL_SUB_OVF_EN
                check("cyc_ovf", ovf, pend_ovf);
`endif
            end else begin
                check("cyc_d_hold", d, prev_d);
                check("cyc_bo_hold", bo, prev_bo);
`ifdef SERIAL_SUB_OVF_EN
                check("cyc_ovf_hold", ovf, prev_ovf);
`endif
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic c, input logic [31:0] ed, input logic ebo,
                          input logic eovf, input int stall);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin tick(); n++; end
        check({tag, "_ready_wait"}, (n < 50), 1);
        in_valid = 1'b1; x = a; y = b; bi = c;
        tick();
        // Operands change after acceptance; must not affect the result.
        in_valid = 1'b0; x = ~a; y = ~b; bi = ~c;
        n = 0;
        while (!out_valid && n < 20) begin
            if (n == 1) in_valid = 1'b1;
            if (n == 2) in_valid = 1'b0;
            tick();
            n++;
        end
        in_valid = 1'b0;
        check({tag, "_latency"}, n + 1, CH + 1);
        check({tag, "_d"}, d, ed);
        check({tag, "_bo"}, bo, ebo);
`ifdef SERIAL_SUB_OVF_EN
        check({tag, "_ovf"}, ovf, eovf);
`else
        if (eovf === 1'bx) check({tag, "_ovf_arg"}, eovf, 0);
`endif
        for (int i = 0; i < stall; i++) begin
            tick();
            check({tag, "_stall_in_ready"}, in_ready, 0);
            check({tag, "_stall_valid"}, out_valid, 1);
            check({tag, "_stall_d"}, d, ed);
            check({tag, "_stall_bo"}, bo, ebo);
`ifdef SERIAL_SUB_OVF_EN
            check({tag, "_stall_ovf"}, ovf, eovf);
`endif
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_post_in_ready"}, in_ready, 1);
        check({tag, "_post_valid"}, out_valid, 0);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        x = '0; y = '0; bi = 1'b0;
        tick(); tick();
        rst = 1'b0;
        #1;
        check("release_in_ready", in_ready, 1);
        check("release_d", d, 0);

        run_op("sub_5_3",   32'd5,          32'd1 + 32'd2, 1'b0, 32'd2,          1'b0, 1'b0, 0);
        run_op("sub_0_1",   32'd0,          32'd1,         1'b0, 32'hFFFF_FFFF,  1'b1, 1'b0, 0);
        run_op("sub_min_1", 32'h8000_0000,  32'd1,         1'b0, 32'h7FFF_FFFF,  1'b0, 1'b1, 0);
        run_op("sub_ff_bi", 32'hFFFF_FFFF,  32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF,  1'b1, 1'b0, 0);
        run_op("stall",     32'h1234_5678,  32'h0000_5678, 1'b0, 32'h1234_0000,  1'b0, 1'b0, 3);
        run_op("chain",     32'h0001_0000,  32'h0000_0001, 1'b1, 32'h0000_FFFE,  1'b0, 1'b0, 0);

        // Reset in the second RUN cycle aborts the operation.
        while (!in_ready) tick();
        in_valid = 1'b1; x = 32'd100; y = 32'd1; bi = 1'b0;
        tick();
        in_valid = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        check("abort_in_ready", in_ready, 0);
        check("abort_out_valid", out_valid, 0);
        check("abort_d", d, 0);
        check("abort_bo", bo, 0);
`ifdef SERIAL_SUB_OVF_EN
        check("abort_ovf", ovf, 0);
`endif
        tick();
        rst = 1'b0;
        #1;
        check("abort_release_ready", in_ready, 1);
        for (int i = 0; i < 8; i++) begin
            tick();
            check("abort_no_valid", out_valid, 0);
        end

        run_op("after_rst", 32'd10, 32'd4, 1'b0, 32'd6, 1'b0, 1'b0, 0);

        tick(); tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
